data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (`d_address`/`d_data`, `d_readM`/`d_writeM`) and the line-wide data memory. It replaces the fixed-latency D-memory access. On a hit it returns data in two cycles. On a miss it stalls the requester while it writes back a dirty victim line if needed and then fills the line. It also keeps hit and miss counters for the cache experiments.

## Interface
- `INDEX_BITS`, 2, number of lines is 2^INDEX_BITS; line size is fixed at 4 words of `WORD_SIZE` (16) bits.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-high reset. The name is kept for codebase consistency; asserted = 1.
- `cpu_readM` in 1: read request, held until `cpu_ready`.
- `cpu_writeM` in 1: write request, held until `cpu_ready`.
- `cpu_address` in 16: word address. Bits [1:0] are the offset, [INDEX_BITS+1:2] the index, the remainder the tag.
- `cpu_wdata` in 16: store data.
- `cpu_rdata` out 16: load data, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `mem_readM` out 1: line read request.
- `mem_writeM` out 1: line write request.
- `mem_address` out 16: line-aligned word address (bits [1:0]=0).
- `mem_wdata` out 64: victim line, word 0 in bits [15:0].
- `mem_rdata` in 64: fill line, same packing.
- `mem_ready` in 1: one-cycle pulse marking completion of the current memory request.
- `hit_count` out 16: wrapping hit counter.
- `miss_count` out 16: wrapping miss counter.

## Operation
- Per line storage: valid, dirty, tag, 4 data words.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE
  - If `cpu_ready`=0 and (`cpu_readM` | `cpu_writeM`), latch the address, wdata and op, then go to COMPARE.
  - If both request signals are high, the request is a write.
  - No request is accepted in a cycle where `cpu_ready`=1.
- COMPARE, hit (valid and tag match)
  - Read: `cpu_rdata` <= word.
  - Write: word <= wdata and dirty <= 1.
  - Then `cpu_ready` <= 1 and go to IDLE.
  - `hit_count` += 1, only on the first COMPARE of a request.
- COMPARE, miss
  - `miss_count` += 1.
  - If valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK
  - `mem_writeM`=1, `mem_address`={victim tag, index, 2'b00}, `mem_wdata`=victim line.
  - On `mem_ready`, go to FILL.
- FILL
  - `mem_readM`=1, `mem_address`={req tag, index, 2'b00}.
  - On `mem_ready`: line <= `mem_rdata`, valid <= 1, dirty <= 0, tag <= req tag, then go to COMPARE.
  - The second COMPARE always hits and does not increment `hit_count`; this is tracked by a "refilled" flag.
- Outputs `mem_readM`, `mem_writeM`, `mem_address` and `mem_wdata` are Moore outputs decoded from state and latched request; they are 0 outside WRITEBACK/FILL.
- `mem_ready` outside WRITEBACK/FILL is ignored.
- The counters wrap from 0xFFFF to 0x0000.

## Timing
- Reset (`reset_n`=1 at an edge) takes effect at that edge:
  - state = IDLE;
  - all valid and dirty bits = 0 (dirty data is discarded, no writeback);
  - `cpu_ready`=0, `cpu_rdata`=0;
  - `mem_readM` = `mem_writeM` = 0, `mem_address`=0, `mem_wdata`=0;
  - both counters = 0.
  - Reset during WRITEBACK/FILL drops the memory request in the next cycle.
- Hit latency: request sampled at edge E0, COMPARE during E0–E1, `cpu_ready`=1 for exactly the cycle after E1.
- Clean miss: E0 sample, E1 enter FILL. If `mem_ready` arrives at edge E1+k (k ≥ 1, counting the edge of its assertion), then E1+k returns to COMPARE and `cpu_ready`=1 after E1+k+1.
- Dirty miss adds the WRITEBACK duration before FILL.
- `mem_ready` in the same cycle the request first appears is legal (1-cycle memory).
- The tag/data array updates on a write hit are visible to the next request (no bypass needed, since requests are serialized).
- The requester must keep its request stable until `cpu_ready`. A request still asserted in the cycle after the `cpu_ready` cycle is treated as a new request.

## Test plan
- **Cold read.** Memory line 0x0010 = {0x4444, 0x3333, 0x2222, 0x1111}; read 0x0012.
  - One FILL with `mem_address`=0x0010, no WRITEBACK.
  - `cpu_rdata`=0x3333.
  - `miss_count`=1, `hit_count`=0.
- **Read hit.** Then read 0x0011: `cpu_ready` 2 cycles after the request, `cpu_rdata`=0x2222, `hit_count`=1, no memory activity.
- **Write hit then dirty eviction.**
  - Write 0xBEEF to 0x0012 (hit, no memory traffic).
  - Read 0x0022: WRITEBACK with `mem_address`=0x0010 and `mem_wdata`=0x4444_BEEF_2222_1111, then FILL at 0x0020.
  - `miss_count`=2.
- **Clean conflict.** Read 0x0012 again: WRITEBACK of 0x0020 only if that line is dirty (here it is clean, so FILL only); the returned data is 0xBEEF from memory.
- **Memory latency sweep.** `mem_ready` delays of 1, 3 and 10 cycles: `cpu_ready` is exactly one pulse each time, and `mem_readM` drops the cycle after `mem_ready`.
- **Reset mid-FILL.** Assert `reset_n`=1 during FILL:
  - the next cycle has `mem_readM`=0 and counters at 0;
  - a subsequent read of a previously cached address misses.

Source files
------------

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-back, write-allocate data cache placed between the
//   pipeline MEM stage and a line-wide data memory. Hits complete two cycles
//   after the request is sampled; misses stall the requester while a dirty
//   victim is written back (if needed) and the line is refilled.
//
// Ports
//   clk, reset_n              rising-edge clock, synchronous active-high reset
//   cpu_readM / cpu_writeM    request strobes, held until cpu_ready
//   cpu_address, cpu_wdata    word address and store data
//   cpu_rdata, cpu_ready      load data and one-cycle completion pulse
//   mem_readM / mem_writeM    line read / write request to memory
//   mem_address, mem_wdata    line-aligned address and victim line
//   mem_rdata, mem_ready      fill line and one-cycle memory completion pulse
//   hit_count, miss_count     wrapping 16-bit experiment counters

module data_cache #(
    parameter int INDEX_BITS = 2,
    parameter int WORD_SIZE  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_readM,
    input  logic                   cpu_writeM,
    input  logic [15:0]            cpu_address,
    input  logic [WORD_SIZE-1:0]   cpu_wdata,
    output logic [WORD_SIZE-1:0]   cpu_rdata,
    output logic                   cpu_ready,
    output logic                   mem_readM,
    output logic                   mem_writeM,
    output logic [15:0]            mem_address,
    output logic [4*WORD_SIZE-1:0] mem_wdata,
    input  logic [4*WORD_SIZE-1:0] mem_rdata,
    input  logic                   mem_ready,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    localparam int LINES     = 1 << INDEX_BITS;
    localparam int TAG_BITS  = 16 - INDEX_BITS - 2;
    localparam int LINE_BITS = 4 * WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FILL
    } state_t;

    state_t state;

    logic [LINES-1:0]     valid;
    logic [LINES-1:0]     dirty;
    logic [TAG_BITS-1:0]  tag_arr  [LINES];
    logic [LINE_BITS-1:0] data_arr [LINES];

    logic [15:0]          req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 req_write;
    // Set once the line has been refilled so the re-run COMPARE is not
    // counted as a hit.
    logic                 refilled;

    logic [1:0]            req_offset;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [LINE_BITS-1:0]  cur_line;
    logic                  hit;

    assign req_offset = req_addr[1:0];
    assign req_index  = req_addr[INDEX_BITS+1:2];
    assign req_tag    = req_addr[15:INDEX_BITS+2];
    assign cur_line   = data_arr[req_index];
    assign hit        = valid[req_index] && (tag_arr[req_index] == req_tag);

    // Memory-side outputs depend only on the state and the latched request.
    always_comb begin
        mem_readM   = 1'b0;
        mem_writeM  = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state)
            WRITEBACK: begin
                mem_writeM  = 1'b1;
                mem_address = {tag_arr[req_index], req_index, 2'b00};
                mem_wdata   = cur_line;
            end
            FILL: begin
                mem_readM   = 1'b1;
                mem_address = {req_tag, req_index, 2'b00};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state      <= IDLE;
            valid      <= '0;
            dirty      <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_write  <= 1'b0;
            refilled   <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // The completion cycle itself never starts a new request.
                    if (!cpu_ready && (cpu_readM || cpu_writeM)) begin
                        req_addr  <= cpu_address;
                        req_wdata <= cpu_wdata;
                        req_write <= cpu_writeM;
                        refilled  <= 1'b0;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_write) begin
                            data_arr[req_index][int'(req_offset)*WORD_SIZE +: WORD_SIZE] <= req_wdata;
                            dirty[req_index] <= 1'b1;
                        end else begin
                            cpu_rdata <= cur_line[int'(req_offset)*WORD_SIZE +: WORD_SIZE];
                        end
                        if (!refilled) begin
                            hit_count <= hit_count + 16'd1;
                        end
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        miss_count <= miss_count + 16'd1;
                        if (valid[req_index] && dirty[req_index]) begin
                            state <= WRITEBACK;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        data_arr[req_index] <= mem_rdata;
                        tag_arr[req_index]  <= req_tag;
                        valid[req_index]    <= 1'b1;
                        dirty[req_index]    <= 1'b0;
                        refilled            <= 1'b1;
                        state               <= COMPARE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
//   Self-checking bench for data_cache. A line-granular memory responder with
//   programmable latency serves the cache; a reference model (valid/dirty/tag/
//   line per index plus counters) predicts the cycle-by-cycle outputs of each
//   request, and a compare process checks every cycle against that schedule.
//   Literal expectations pin the model at key points.

module tb_data_cache;

    logic        clk;
    logic        reset_n;
    logic        cpu_readM;
    logic        cpu_writeM;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_readM;
    logic        mem_writeM;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    data_cache #(.INDEX_BITS(2), .WORD_SIZE(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_readM   (cpu_readM),
        .cpu_writeM  (cpu_writeM),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .mem_readM   (mem_readM),
        .mem_writeM  (mem_writeM),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic check_enable = 1'b0;

    // Expected output values for one cycle.
    typedef struct {
        logic        ready;
        logic        mrd;
        logic        mwr;
        logic [15:0] maddr;
        logic [63:0] mwdata;
        logic [15:0] hits;
        logic [15:0] misses;
        logic        chk_rdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    // Reference cache model.
    logic        m_valid [4];
    logic        m_dirty [4];
    logic [11:0] m_tag   [4];
    logic [63:0] m_line  [4];
    logic [15:0] m_hits;
    logic [15:0] m_misses;

    // Simulated memory (written by the DUT) and the model's view of it.
    logic [63:0] mem_array [logic [15:0]];
    logic [63:0] ref_mem   [logic [15:0]];

    int          mem_delay = 1;
    int          mem_cnt = 0;
    int          wb_count = 0;
    int          fill_count = 0;
    logic [15:0] last_wb_addr = '0;
    logic [63:0] last_wb_data = '0;
    logic [15:0] last_fill_addr = '0;

    // Lines never written explicitly hold word k = line address + k*0x100.
    function automatic logic [63:0] init_line(input logic [15:0] a);
        return {a + 16'h0300, a + 16'h0200, a + 16'h0100, a};
    endfunction

    function automatic logic [63:0] mem_read(input logic [15:0] a);
        if (mem_array.exists(a)) return mem_array[a];
        return init_line(a);
    endfunction

    function automatic logic [63:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_line(a);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void push_exp(input logic ready, input logic mrd, input logic mwr,
                                     input logic [15:0] maddr, input logic [63:0] mwdata,
                                     input logic chk_rdata, input logic [15:0] rdata);
        exp_t e;
        e.ready     = ready;
        e.mrd       = mrd;
        e.mwr       = mwr;
        e.maddr     = maddr;
        e.mwdata    = mwdata;
        e.hits      = m_hits;
        e.misses    = m_misses;
        e.chk_rdata = chk_rdata;
        e.rdata     = rdata;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
            m_line[i]  = '0;
        end
        m_hits   = '0;
        m_misses = '0;
    endfunction

    // Memory responder: raises mem_ready for one cycle once a request has been
    // visible for mem_delay cycles (1 means in its first cycle).
    always @(negedge clk) begin
        if (mem_ready) mem_cnt = 0;
        if (mem_readM || mem_writeM) begin
            mem_cnt++;
            if (mem_cnt >= mem_delay) begin
                mem_ready = 1'b1;
                if (mem_writeM) begin
                    mem_array[mem_address] = mem_wdata;
                    wb_count++;
                    last_wb_addr = mem_address;
                    last_wb_data = mem_wdata;
                end else begin
                    mem_rdata = mem_read(mem_address);
                    fill_count++;
                    last_fill_addr = mem_address;
                end
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            mem_cnt   = 0;
            mem_ready = 1'b0;
        end
    end

    // Per-cycle comparison against the predicted schedule (idle when empty).
    always @(negedge clk) begin
        exp_t e;
        if (check_enable) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '{ready: 1'b0, mrd: 1'b0, mwr: 1'b0, maddr: 16'h0, mwdata: 64'h0,
                      hits: m_hits, misses: m_misses, chk_rdata: 1'b0, rdata: 16'h0};
            end
            checkOutput("cpu_ready",   cpu_ready,   e.ready);
            checkOutput("mem_readM",   mem_readM,   e.mrd);
            checkOutput("mem_writeM",  mem_writeM,  e.mwr);
            checkOutput("mem_address", mem_address, e.maddr);
            checkOutput("mem_wdata",   mem_wdata,   e.mwdata);
            checkOutput("hit_count",   hit_count,   e.hits);
            checkOutput("miss_count",  miss_count,  e.misses);
            if (e.chk_rdata) checkOutput("cpu_rdata", cpu_rdata, e.rdata);
        end
    end

    // Issues one request, predicts its schedule from the model, and returns
    // #1 after the negedge inside the completion cycle.
    task automatic applyStimulus(input logic is_write, input logic both, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int delay);
        logic [1:0]  idx;
        logic [11:0] tg;
        int          off;
        logic [15:0] line_addr;
        logic [15:0] victim;
        int          n;
        @(negedge clk);
        #1;
        mem_delay = delay;
        idx       = addr[3:2];
        tg        = addr[15:4];
        off       = int'(addr[1:0]);
        line_addr = {addr[15:2], 2'b00};
        n         = 0;
        push_exp(1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0);
        n++;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            m_hits = m_hits + 16'd1;
        end else begin
            m_misses = m_misses + 16'd1;
            if (m_valid[idx] && m_dirty[idx]) begin
                victim = {m_tag[idx], idx, 2'b00};
                for (int i = 0; i < delay; i++) begin
                    push_exp(1'b0, 1'b0, 1'b1, victim, m_line[idx], 1'b0, 16'h0);
                    n++;
                end
                ref_mem[victim] = m_line[idx];
            end
            for (int i = 0; i < delay; i++) begin
                push_exp(1'b0, 1'b1, 1'b0, line_addr, 64'h0, 1'b0, 16'h0);
                n++;
            end
            m_line[idx]  = ref_read(line_addr);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
            push_exp(1'b0, 1'b0, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0);
            n++;
        end
        if (is_write) begin
            m_line[idx][off*16 +: 16] = wdata;
            m_dirty[idx] = 1'b1;
            push_exp(1'b1, 1'b0, 1'b0, 16'h0, 64'h0, 1'b0, 16'h0);
        end else begin
            push_exp(1'b1, 1'b0, 1'b0, 16'h0, 64'h0, 1'b1, m_line[idx][off*16 +: 16]);
        end
        n++;
        cpu_address = addr;
        cpu_wdata   = wdata;
        cpu_writeM  = is_write;
        cpu_readM   = !is_write || both;
        repeat (n) @(negedge clk);
        #1;
        cpu_readM  = 1'b0;
        cpu_writeM = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        cpu_readM   = 1'b0;
        cpu_writeM  = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        model_reset();
        mem_array[16'h0010] = 64'h4444_3333_2222_1111;
        ref_mem[16'h0010]   = 64'h4444_3333_2222_1111;
        mem_array[16'h0020] = 64'h8888_7777_6666_5555;
        ref_mem[16'h0020]   = 64'h8888_7777_6666_5555;

        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_cpu_ready",  cpu_ready,   1'b0);
        checkOutput("reset_cpu_rdata",  cpu_rdata,   16'h0);
        checkOutput("reset_mem_readM",  mem_readM,   1'b0);
        checkOutput("reset_mem_writeM", mem_writeM,  1'b0);
        checkOutput("reset_mem_addr",   mem_address, 16'h0);
        checkOutput("reset_mem_wdata",  mem_wdata,   64'h0);
        checkOutput("reset_hits",       hit_count,   16'h0);
        checkOutput("reset_misses",     miss_count,  16'h0);
        #1;
        reset_n      = 1'b0;
        check_enable = 1'b1;

        // Cold read
        applyStimulus(1'b0, 1'b0, 16'h0012, 16'h0, 2);
        checkOutput("cold_rdata",     cpu_rdata,      16'h3333);
        checkOutput("cold_misses",    miss_count,     16'd1);
        checkOutput("cold_hits",      hit_count,      16'd0);
        checkOutput("cold_fill_addr", last_fill_addr, 16'h0010);
        checkOutput("cold_fills",     fill_count,     1);
        checkOutput("cold_wbs",       wb_count,       0);

        // Read hit
        applyStimulus(1'b0, 1'b0, 16'h0011, 16'h0, 1);
        checkOutput("hit_rdata", cpu_rdata,  16'h2222);
        checkOutput("hit_hits",  hit_count,  16'd1);
        checkOutput("hit_fills", fill_count, 1);

        // Write hit then dirty eviction
        applyStimulus(1'b1, 1'b0, 16'h0012, 16'hBEEF, 1);
        checkOutput("whit_hits",  hit_count,  16'd2);
        checkOutput("whit_fills", fill_count, 1);
        applyStimulus(1'b0, 1'b0, 16'h0022, 16'h0, 3);
        checkOutput("evict_wb_addr",   last_wb_addr,   16'h0010);
        checkOutput("evict_wb_data",   last_wb_data,   64'h4444_BEEF_2222_1111);
        checkOutput("evict_fill_addr", last_fill_addr, 16'h0020);
        checkOutput("evict_misses",    miss_count,     16'd2);
        checkOutput("evict_rdata",     cpu_rdata,      16'h7777);

        // Clean conflict
        applyStimulus(1'b0, 1'b0, 16'h0012, 16'h0, 1);
        checkOutput("conflict_wbs",    wb_count,   1);
        checkOutput("conflict_rdata",  cpu_rdata,  16'hBEEF);
        checkOutput("conflict_misses", miss_count, 16'd3);

        // Memory latency sweep, including a both-strobes write and a dirty
        // eviction with long latency.
        applyStimulus(1'b0, 1'b0, 16'h0105, 16'h0, 10);
        checkOutput("sweep10_rdata", cpu_rdata, 16'h0204);
        applyStimulus(1'b1, 1'b1, 16'h0106, 16'hCAFE, 1);
        checkOutput("both_hits", hit_count, 16'd3);
        applyStimulus(1'b0, 1'b0, 16'h0209, 16'h0, 3);
        checkOutput("sweep3_rdata", cpu_rdata, 16'h0308);
        applyStimulus(1'b0, 1'b0, 16'h0204, 16'h0, 10);
        checkOutput("sweep_wb_data", last_wb_data, 64'h0404_CAFE_0204_0104);
        checkOutput("sweep_rdata",   cpu_rdata,    16'h0204);
        applyStimulus(1'b0, 1'b0, 16'h0106, 16'h0, 1);
        checkOutput("sweep1_rdata",  cpu_rdata,  16'hCAFE);
        checkOutput("sweep_misses",  miss_count, 16'd7);

        // Dirty line that reset must discard
        applyStimulus(1'b1, 1'b0, 16'h0013, 16'h1234, 1);
        checkOutput("predirty_hits", hit_count, 16'd4);

        // Reset mid-FILL
        @(negedge clk);
        #1;
        check_enable = 1'b0;
        mem_delay    = 10;
        cpu_address  = 16'h030C;
        cpu_readM    = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midfill_readM", mem_readM,   1'b1);
        checkOutput("midfill_addr",  mem_address, 16'h030C);
        #1;
        reset_n   = 1'b1;
        cpu_readM = 1'b0;
        @(negedge clk);
        checkOutput("rst_fill_readM",  mem_readM,  1'b0);
        checkOutput("rst_fill_hits",   hit_count,  16'h0);
        checkOutput("rst_fill_misses", miss_count, 16'h0);
        checkOutput("rst_fill_ready",  cpu_ready,  1'b0);
        checkOutput("rst_fill_rdata",  cpu_rdata,  16'h0);
        #1;
        reset_n = 1'b0;
        model_reset();
        check_enable = 1'b1;

        applyStimulus(1'b0, 1'b0, 16'h0013, 16'h0, 2);
        checkOutput("post_rst_rdata",  cpu_rdata,  16'h4444);
        checkOutput("post_rst_misses", miss_count, 16'd1);
        checkOutput("post_rst_hits",   hit_count,  16'd0);
        checkOutput("post_rst_wbs",    wb_count,   2);
        applyStimulus(1'b0, 1'b0, 16'h0012, 16'h0, 1);
        checkOutput("post_rst_hit_rdata", cpu_rdata, 16'hBEEF);
        checkOutput("post_rst_hit_hits",  hit_count, 16'd1);

        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
